pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter RESET_VAL, default 0, payload value after reset or flush.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port stall  input  1  freeze request; state held.
REQ-007 SHALL have port bubble  input  1  flush request; stage emptied.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port out_valid  output  1  stage presents payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts payload.
REQ-013 SHALL have port out_data  output  WIDTH  registered payload.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-015 Input transfer SHALL occur on an edge where in_valid=1 and in_ready=1; output transfer where out_valid=1 and out_ready=1.
REQ-016 Main register SHALL hold main_valid/main_data; out_data = main_data; out_valid = main_valid AND NOT stall.
REQ-017 Latency SHALL be 1 cycle: data accepted at edge N appears on out_data after edge N when main register is free.
REQ-018 in_ready SHALL be 0 whenever stall=1 or bubble=1.
REQ-019 Stall (priority over bubble) SHALL hold main and skid contents unchanged; out_ready and in_valid ignored.
REQ-020 Bubble with stall=0 SHALL, at next edge, clear main_valid and skid_valid, load main_data=RESET_VAL; in_data discarded.
REQ-021 With neither stall nor bubble, output transfer with no input transfer SHALL clear main_valid; main_data holds.
REQ-022 Simultaneous input and output transfer SHALL load in_data into main register, main_valid stays 1.
REQ-023 stall_cnt SHALL increment by 1 every edge with stall=1, saturate at 2^CNT_W-1, never wrap.
REQ-024 Payload order SHALL be preserved; no payload duplicated or lost except by bubble.

Reset
REQ-025 nrst=0 SHALL immediately force main_valid=0, main_data=RESET_VAL, skid_valid=0, skid_data=RESET_VAL, stall_cnt=0, independent of clk.
REQ-026 Reset mid-transfer SHALL discard all held payloads; first edge after release behaves as empty stage.

Configuration
REQ-027 Macro PIPE_STAGE_REG_SKID_EN SHALL select the skid buffer.
REQ-028 Without macro: in_ready = NOT stall AND NOT bubble AND (out_ready OR NOT main_valid), combinational from out_ready; no skid state.
REQ-029 With macro: one skid entry; in_ready = NOT stall AND NOT bubble AND NOT skid_valid (no out_ready path); payload accepted while main full and not draining goes to skid.
REQ-030 With macro: when main drains (or is empty) and skid_valid=1, skid SHALL move to main at that edge, skid_valid cleared; new input then loads skid only if main still occupied.

Verification
REQ-031 Reset release, in_data=0x1234_5678, in_valid=1, out_ready=1 -> out_valid=1, out_data=0x1234_5678 after one edge.
REQ-032 Stream 0xA,0xB,0xC with out_ready=1 -> outputs 0xA,0xB,0xC on consecutive cycles, in_ready constant 1.
REQ-033 Main holds 0x5, stall=1 for 3 cycles -> out_valid=0, out_data=0x5, in_ready=0, stall_cnt=3; release -> out_valid=1.
REQ-034 Main holds 0x7, bubble=1 with stall=0 -> next cycle out_valid=0, out_data=RESET_VAL; bubble+stall together -> no flush.
REQ-035 SKID_EN: main holds 0x1, out_ready=0, send 0x2 -> accepted, in_ready=0 next; out_ready=1 -> 0x1 then 0x2 delivered in order.
REQ-036 CNT_W=2, stall=1 for 6 cycles -> stall_cnt 1,2,3,3,3,3; nrst pulse -> 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Single pipeline stage register with stall/bubble control and a saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer that cuts the out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             stall,
  input  logic             bubble,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = main_valid & ~stall;
  assign out_data  = main_data;
  assign out_xfer  = out_valid & out_ready;
  assign in_xfer   = in_valid & in_ready;

  // Counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             drain;

  // Main is free at this edge if it is empty or its payload is leaving.
  assign drain    = out_xfer | ~main_valid;
  assign in_ready = ~stall & ~bubble & ~skid_valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
    end else if (stall) begin
      main_valid <= main_valid;
    end else if (bubble) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
    end else if (skid_valid) begin
      // in_ready is low here, so only the skid -> main move can happen.
      if (drain) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (drain) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~stall & ~bubble & (out_ready | ~main_valid);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
    end else if (stall) begin
      main_valid <= main_valid;
    end else if (bubble) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        stall = 1'b0, bubble = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  sat_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt));

  pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) u_sat (
    .clk(clk), .nrst(nrst), .stall(stall), .bubble(1'b0),
    .in_valid(1'b0), .in_ready(s_in_ready), .in_data(8'h00),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .stall_cnt(sat_cnt));

  int checks = 0, errors = 0;

  // Model: stage contents as an ordered queue; 'last' is what out_data shows when empty.
  logic [31:0] q[$];
  logic [31:0] last;
  int          cnt, cnt2;

  logic        pre_ready, pre_ovalid;
  logic [31:0] pre_odata;
  logic        exp_ready, exp_ovalid;
  logic [31:0] exp_odata;

  function automatic logic m_in_ready();
    if (stall || bubble) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic m_out_valid();
    return (q.size() > 0) && !stall;
  endfunction

  function automatic logic [31:0] m_out_data();
    return (q.size() > 0) ? q[0] : last;
  endfunction

  function automatic void m_reset();
    q.delete();
    last = RV;
    cnt = 0;
    cnt2 = 0;
  endfunction

  function automatic void m_edge();
    logic ixf, oxf;
    if (stall) begin
      if (cnt < 65535) cnt++;
      if (cnt2 < 3) cnt2++;
    end else if (bubble) begin
      q.delete();
      last = RV;
    end else begin
      ixf = in_valid && m_in_ready();
      oxf = m_out_valid() && out_ready;
      if (oxf) last = q.pop_front();
      if (ixf) q.push_back(in_data);
    end
  endfunction

  // Drive one cycle: sample combinational outputs before the edge, advance model, settle after edge.
  task automatic tick(input logic st, input logic bb, input logic iv,
                      input logic [31:0] d, input logic ordy);
    stall = st; bubble = bb; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    pre_ready = in_ready; pre_ovalid = out_valid; pre_odata = out_data;
    exp_ready = m_in_ready(); exp_ovalid = m_out_valid(); exp_odata = m_out_data();
    m_edge();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    stall = 0; bubble = 0; in_valid = 0; out_ready = 0;
    #2 nrst = 1'b0;
    m_reset();
    #7 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 32'hCAFE_0001, 0);
    stall = 0; bubble = 0; in_valid = 0; out_ready = 0;
    #2 nrst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== RV || stall_cnt !== 16'd0 || sat_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h cnt=%0d sat=%0d want 0 %h 0 0",
               out_valid, out_data, stall_cnt, sat_cnt, RV);
    end
    #6 nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_first();
    apply_reset();
    tick(0, 0, 1, 32'h1234_5678, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL first_xfer: valid=%b data=%h want 1 12345678", out_valid, out_data);
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_stream();
    logic [31:0] vals[3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, vals[i], 1);
      checks++;
      if (pre_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== vals[i]) begin
        errors++;
        $display("FAIL stream[%0d]: in_ready=%b valid=%b data=%h want 1 1 %h",
                 i, pre_ready, out_valid, out_data, vals[i]);
      end
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_stall();
    apply_reset();
    tick(0, 0, 1, 32'h5, 0);
    for (int i = 1; i <= 3; i++) tick(1, 0, 1, 32'h99, 1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h5 || in_ready !== 1'b0 || stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_hold: valid=%b data=%h in_ready=%b cnt=%0d want 0 5 0 3",
               out_valid, out_data, in_ready, stall_cnt);
    end
    stall = 0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5) begin
      errors++;
      $display("FAIL stall_release: valid=%b data=%h want 1 5", out_valid, out_data);
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_bubble();
    apply_reset();
    tick(0, 0, 1, 32'h7, 0);
    tick(1, 1, 1, 32'h8, 0);
    tick(0, 0, 0, 0, 0);
    checks++;
    if (pre_ovalid !== 1'b1 || pre_odata !== 32'h7) begin
      errors++;
      $display("FAIL bubble_with_stall: valid=%b data=%h want 1 7", pre_ovalid, pre_odata);
    end
    tick(0, 1, 1, 32'h9, 1);
    checks++;
    if (pre_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== RV) begin
      errors++;
      $display("FAIL bubble_flush: in_ready=%b valid=%b data=%h want 0 0 %h",
               pre_ready, out_valid, out_data, RV);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    tick(0, 0, 1, 32'h1, 0);
    tick(0, 0, 1, 32'h2, 0);
    checks++;
    if (pre_ready !== exp_ready) begin
      errors++;
      $display("FAIL full_in_ready: got %b want %b", pre_ready, exp_ready);
    end
    stall = 0; bubble = 0; in_valid = 0; #1;
    checks++;
    if (in_ready !== m_in_ready() || out_data !== 32'h1) begin
      errors++;
      $display("FAIL after_push: in_ready=%b data=%h want %b 1", in_ready, out_data, m_in_ready());
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if (pre_odata !== 32'h1 || out_valid !== exp_ovalid_next() || out_data !== m_out_data()) begin
      errors++;
      $display("FAIL drain_order1: pre=%h valid=%b data=%h want 1 %b %h",
               pre_odata, out_valid, out_data, exp_ovalid_next(), m_out_data());
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== ((CAP == 2) ? 32'h2 : 32'h1)) begin
      errors++;
      $display("FAIL drain_order2: valid=%b data=%h", out_valid, out_data);
    end
  endtask

  function automatic logic exp_ovalid_next();
    return q.size() > 0;
  endfunction

  task automatic test_saturate();
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (sat_cnt !== 2'((i > 3) ? 3 : i) || stall_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL sat_cnt[%0d]: got %0d/%0d want %0d/%0d", i, sat_cnt, stall_cnt,
                 (i > 3) ? 3 : i, i);
      end
    end
    stall = 0;
    #2 nrst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (sat_cnt !== 2'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sat_reset: got %0d/%0d want 0/0", sat_cnt, stall_cnt);
    end
    #6 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 3) != 0,
           $urandom, ($urandom % 4) != 0);
      checks++;
      if (pre_ready !== exp_ready || pre_ovalid !== exp_ovalid ||
          (exp_ovalid && pre_odata !== exp_odata) || out_data !== m_out_data() ||
          stall_cnt !== 16'(cnt)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: rdy=%b vld=%b pdat=%h dat=%h cnt=%0d want %b %b %h %h %0d",
                   i, pre_ready, pre_ovalid, pre_odata, out_data, stall_cnt,
                   exp_ready, exp_ovalid, exp_odata, m_out_data(), cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 1, 32'h4242, 0);
    tick(0, 0, 1, 32'h4343, 0);
    apply_reset();
    tick(0, 0, 1, 32'h55, 0);
    checks++;
    if (pre_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h55) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b valid=%b data=%h want 1 1 55", pre_ready, out_valid, out_data);
    end
  endtask

  initial begin
    m_reset();
    #12 nrst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_first();
    test_stream();
    test_stall();
    test_bubble();
    test_backpressure();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
